md_run_sequencer: RTL and testbench

- Parametrised successor to the board-level run harness.
- Replaces a fixed "hold reset N cycles, run M cycles" sequence with a synthesisable sequencer. It drives CHANNELS staggered reset lines into md_board sub-blocks, times a run window, and checks that the core is moving.
- Movement check: an activity/stall monitor on a probe bus, with a pass/fail verdict.
- Sits between board clock/reset and the md_board reset inputs; usable in simulation and in FPGA bring-up.

---
 rtl/md_run_pkg.sv | 21 ++
 rtl/md_activity_mon.sv | 68 ++++++
 rtl/md_run_sequencer.sv | 164 ++++++++++++++++
 tb/tb_md_run_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/md_run_pkg.sv
// Shared types and constants for the run sequencer slice.
// No logic: state encoding, default widths and the minimum-length rule.
// No flow control.
package md_run_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RESET   = 3'd1,
        ST_RELEASE = 3'd2,
        ST_RUN     = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam int DEF_CNT_W = 16;
    localparam int DEF_MON_W = 16;

    // A requested length of zero is promoted to this value so every phase lasts at least one cycle
    localparam int LEN_MIN = 1;

endpackage

// File: rtl/md_activity_mon.sv
// Activity/stall monitor: flags probe-bus movement and long runs without movement.
// Latency: probe sampled every cycle; flags update on the edge after the observed cycle.
// Backpressure: none; purely observes the probe bus while enabled.
module md_activity_mon #(
    parameter int MON_W       = 16,
    parameter int STALL_LIMIT = 64
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic [MON_W-1:0] i_mon,
    output logic             o_stall,
    output logic             o_activity_nxt,
    output logic             o_stall_nxt
);

    localparam int IDLE_W = $clog2(STALL_LIMIT + 1);

    logic [MON_W-1:0]  r_probe;
    logic [IDLE_W-1:0] r_idle;
    logic              r_activity;
    logic              r_stall;

    logic              w_change;
    logic [IDLE_W-1:0] w_idle_nxt;

    // A change only counts while enabled; the probe itself is sampled every cycle
    assign w_change = i_en && (i_mon != r_probe);

    // Next-state values, exported so the owner can form a verdict on the final run cycle
    always_comb begin
        w_idle_nxt     = r_idle;
        o_activity_nxt = r_activity;
        o_stall_nxt    = r_stall;
        if (i_clr) begin
            w_idle_nxt     = '0;
            o_activity_nxt = 1'b0;
            o_stall_nxt    = 1'b0;
        end else if (i_en) begin
            if (w_change) begin
                w_idle_nxt = '0;
            end else if (r_idle != IDLE_W'(STALL_LIMIT)) begin
                w_idle_nxt = r_idle + IDLE_W'(1);
            end
            o_activity_nxt = r_activity | w_change;
            o_stall_nxt    = r_stall | (w_idle_nxt == IDLE_W'(STALL_LIMIT));
        end
    end

    // Probe register, saturating idle counter and sticky flags
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_probe    <= '0;
            r_idle     <= '0;
            r_activity <= 1'b0;
            r_stall    <= 1'b0;
        end else begin
            r_probe    <= i_mon;
            r_idle     <= w_idle_nxt;
            r_activity <= o_activity_nxt;
            r_stall    <= o_stall_nxt;
        end
    end

    assign o_stall = r_stall;

endmodule

// File: rtl/md_run_sequencer.sv
// Run sequencer: holds board resets, releases channels staggered, times a run, judges core movement.
// Latency: start edge t to done at t+1+reset_len+STAGGER*(CHANNELS-1)+run_len (zero lengths act as 1).
// Backpressure: none; start is a pulse honoured only in IDLE/DONE. Optional port dump_en via MD_RUN_SEQ_DUMPWIN_EN.
module md_run_sequencer
    import md_run_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int STAGGER     = 16,
    parameter int MON_W       = DEF_MON_W,
    parameter int STALL_LIMIT = 64
) (
    input  logic                MCLK,
    input  logic                ext_reset,
    input  logic                start,
    input  logic [CNT_W-1:0]    reset_len,
    input  logic [CNT_W-1:0]    run_len,
    input  logic [MON_W-1:0]    mon_bus,
    output logic [CHANNELS-1:0] rst_out,
    output logic                running,
    output logic                done,
    output logic                pass,
    output logic                stall,
    output logic [CNT_W-1:0]    cycle_cnt
`ifdef MD_RUN_SEQ_DUMPWIN_EN
    ,
    output logic                dump_en
`endif
);

    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    state_t              r_state;
    logic [CNT_W-1:0]    r_len_cnt;
    logic [CNT_W-1:0]    r_run_len;
    logic [CNT_W-1:0]    r_stg_cnt;
    logic [CH_W-1:0]     r_ch_idx;
    logic [CHANNELS-1:0] r_rst_out;
    logic                r_running;
    logic                r_done;
    logic                r_pass;
    logic [CNT_W-1:0]    r_cycle_cnt;

    logic                w_start_acc;
    logic [CNT_W-1:0]    w_reset_len_eff;
    logic [CNT_W-1:0]    w_run_len_eff;
    logic                w_act_nxt;
    logic                w_stall_nxt;

    assign w_start_acc     = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_reset_len_eff = (reset_len == '0) ? CNT_W'(LEN_MIN) : reset_len;
    assign w_run_len_eff   = (run_len == '0) ? CNT_W'(LEN_MIN) : run_len;

    md_activity_mon #(
        .MON_W       (MON_W),
        .STALL_LIMIT (STALL_LIMIT)
    ) u_mon (
        .i_clk          (MCLK),
        .i_rst          (ext_reset),
        .i_en           (r_running),
        .i_clr          (w_start_acc),
        .i_mon          (mon_bus),
        .o_stall        (stall),
        .o_activity_nxt (w_act_nxt),
        .o_stall_nxt    (w_stall_nxt)
    );

    // Sequencer FSM with all outputs registered alongside the state.
    // The reset phase counts down from the latched length to zero, so it spans reset_len+1
    // cycles including the start cycle; the run phase loads run_len-1 and spans run_len cycles.
    always_ff @(posedge MCLK or posedge ext_reset) begin
        if (ext_reset) begin
            r_state     <= ST_IDLE;
            r_len_cnt   <= '0;
            r_run_len   <= '0;
            r_stg_cnt   <= '0;
            r_ch_idx    <= '0;
            r_rst_out   <= '1;
            r_running   <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_cycle_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_start_acc) begin
                        r_state     <= ST_RESET;
                        r_len_cnt   <= w_reset_len_eff;
                        r_run_len   <= w_run_len_eff;
                        r_rst_out   <= '1;
                        r_done      <= 1'b0;
                        r_pass      <= 1'b0;
                        r_cycle_cnt <= '0;
                    end
                end
                ST_RESET: begin
                    if (r_len_cnt == '0) begin
                        r_rst_out[0] <= 1'b0;
                        if (CHANNELS == 1) begin
                            // Single channel: no stagger phase at all
                            r_state   <= ST_RUN;
                            r_running <= 1'b1;
                            r_len_cnt <= r_run_len - CNT_W'(1);
                        end else begin
                            r_state   <= ST_RELEASE;
                            r_stg_cnt <= CNT_W'(STAGGER - 1);
                            r_ch_idx  <= CH_W'(1);
                        end
                    end else begin
                        r_len_cnt <= r_len_cnt - CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (r_stg_cnt == '0) begin
                        r_rst_out[r_ch_idx] <= 1'b0;
                        if (r_ch_idx == CH_W'(CHANNELS - 1)) begin
                            // Last channel released on the same edge RUN begins
                            r_state   <= ST_RUN;
                            r_running <= 1'b1;
                            r_len_cnt <= r_run_len - CNT_W'(1);
                        end else begin
                            r_ch_idx  <= r_ch_idx + CH_W'(1);
                            r_stg_cnt <= CNT_W'(STAGGER - 1);
                        end
                    end else begin
                        r_stg_cnt <= r_stg_cnt - CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (r_cycle_cnt != '1) begin
                        r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
                    end
                    if (r_len_cnt == '0) begin
                        r_state   <= ST_DONE;
                        r_running <= 1'b0;
                        r_done    <= 1'b1;
                        // Use next-state flags so the final run cycle is part of the verdict
                        r_pass    <= w_act_nxt & ~w_stall_nxt;
                    end else begin
                        r_len_cnt <= r_len_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_rst_out <= '1;
                    r_running <= 1'b0;
                    r_done    <= 1'b0;
                end
            endcase
        end
    end

    assign rst_out   = r_rst_out;
    assign running   = r_running;
    assign done      = r_done;
    assign pass      = r_pass;
    assign cycle_cnt = r_cycle_cnt;

`ifdef MD_RUN_SEQ_DUMPWIN_EN
    // Dump window is a decode of the registered state: covers the release stagger and the run
    assign dump_en = (r_state == ST_RELEASE) || (r_state == ST_RUN);
`endif

endmodule

// File: tb/tb_md_run_sequencer.sv
// Directed bench for md_run_sequencer with default parameters.
// Edge numbers are counted from the edge that samples an accepted start (edge 0).
// Outputs are sampled 1 time unit after each rising edge.
module tb_md_run_sequencer;

    logic        MCLK;
    logic        ext_reset;
    logic        start;
    logic [15:0] reset_len;
    logic [15:0] run_len;
    logic [15:0] mon_bus;
    logic [3:0]  rst_out;
    logic        running;
    logic        done;
    logic        pass;
    logic        stall;
    logic [15:0] cycle_cnt;
`ifdef MD_RUN_SEQ_DUMPWIN_EN
    logic        dump_en;
`endif

    int checks;
    int errors;
    int edge_n;
    bit mon_inc;

    md_run_sequencer dut (
        .MCLK      (MCLK),
        .ext_reset (ext_reset),
        .start     (start),
        .reset_len (reset_len),
        .run_len   (run_len),
        .mon_bus   (mon_bus),
        .rst_out   (rst_out),
        .running   (running),
        .done      (done),
        .pass      (pass),
        .stall     (stall),
        .cycle_cnt (cycle_cnt)
`ifdef MD_RUN_SEQ_DUMPWIN_EN
        ,
        .dump_en   (dump_en)
`endif
    );

    initial MCLK = 1'b0;
    always #5 MCLK = ~MCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock edge; the probe moves after the edge when incrementing mode is on
    task automatic tick();
        @(posedge MCLK);
        #1;
        edge_n++;
        if (mon_inc) mon_bus = mon_bus + 16'd1;
    endtask

    task automatic run_to(input int target);
        while (edge_n < target) tick();
    endtask

    // Pulse start for the edge that becomes edge 0
    task automatic do_start(input logic [15:0] rl, input logic [15:0] ul);
        reset_len = rl;
        run_len   = ul;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        edge_n    = 0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        edge_n    = 0;
        mon_inc   = 1'b0;
        ext_reset = 1'b1;
        start     = 1'b0;
        reset_len = 16'd0;
        run_len   = 16'd0;
        mon_bus   = 16'd0;
        #22;
        // Reset values
        chk("rst_rst_out", 32'(rst_out), 32'hF);
        chk("rst_running", 32'(running), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_cycle_cnt", 32'(cycle_cnt), 32'd0);
`ifdef MD_RUN_SEQ_DUMPWIN_EN
        chk("rst_dump_en", 32'(dump_en), 32'd0);
`endif
        ext_reset = 1'b0;
        tick();
        tick();
        chk("idle_rst_out", 32'(rst_out), 32'hF);

        // 1. Nominal run, probe increments every cycle
        mon_inc = 1'b1;
        do_start(16'd256, 16'd256);
        run_to(256);
        chk("nom_e256_rst", 32'(rst_out), 32'hF);
`ifdef MD_RUN_SEQ_DUMPWIN_EN
        chk("nom_e256_dump", 32'(dump_en), 32'd0);
`endif
        run_to(257);
        chk("nom_e257_rst", 32'(rst_out), 32'hE);
`ifdef MD_RUN_SEQ_DUMPWIN_EN
        chk("nom_e257_dump", 32'(dump_en), 32'd1);
`endif
        run_to(272);
        chk("nom_e272_rst", 32'(rst_out), 32'hE);
        run_to(273);
        chk("nom_e273_rst", 32'(rst_out), 32'hC);
        run_to(289);
        chk("nom_e289_rst", 32'(rst_out), 32'h8);
        run_to(304);
        chk("nom_e304_running", 32'(running), 32'd0);
        run_to(305);
        chk("nom_e305_rst", 32'(rst_out), 32'h0);
        chk("nom_e305_running", 32'(running), 32'd1);
        run_to(560);
        chk("nom_e560_done", 32'(done), 32'd0);
`ifdef MD_RUN_SEQ_DUMPWIN_EN
        chk("nom_e560_dump", 32'(dump_en), 32'd1);
`endif
        run_to(561);
        chk("nom_e561_done", 32'(done), 32'd1);
        chk("nom_running", 32'(running), 32'd0);
        chk("nom_pass", 32'(pass), 32'd1);
        chk("nom_stall", 32'(stall), 32'd0);
        chk("nom_cycle_cnt", 32'(cycle_cnt), 32'd256);
`ifdef MD_RUN_SEQ_DUMPWIN_EN
        chk("nom_e561_dump", 32'(dump_en), 32'd0);
`endif
        run_to(570);
        chk("nom_hold_done", 32'(done), 32'd1);
        chk("nom_hold_rst", 32'(rst_out), 32'h0);

        // 2 + 5. Restart from DONE with a frozen probe; stray start mid-run
        mon_inc = 1'b0;
        mon_bus = 16'h0000;
        do_start(16'd256, 16'd256);
        chk("restart_done", 32'(done), 32'd0);
        chk("restart_pass", 32'(pass), 32'd0);
        chk("restart_rst", 32'(rst_out), 32'hF);
        chk("restart_cycle_cnt", 32'(cycle_cnt), 32'd0);
        run_to(368);
        chk("stl_e368_stall", 32'(stall), 32'd0);
        run_to(369);
        chk("stl_e369_stall", 32'(stall), 32'd1);
        run_to(399);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("stl_ignored_start_run", 32'(running), 32'd1);
        chk("stl_ignored_start_rst", 32'(rst_out), 32'h0);
        run_to(560);
        chk("stl_e560_done", 32'(done), 32'd0);
        run_to(561);
        chk("stl_e561_done", 32'(done), 32'd1);
        chk("stl_pass", 32'(pass), 32'd0);
        chk("stl_stall_sticky", 32'(stall), 32'd1);
        chk("stl_cycle_cnt", 32'(cycle_cnt), 32'd256);

        // 4. Zero lengths behave as one
        mon_inc = 1'b1;
        do_start(16'd0, 16'd0);
        chk("zero_stall_cleared", 32'(stall), 32'd0);
        run_to(1);
        chk("zero_e1_rst", 32'(rst_out), 32'hF);
        run_to(2);
        chk("zero_e2_rst", 32'(rst_out), 32'hE);
        run_to(50);
        chk("zero_e50_done", 32'(done), 32'd0);
        chk("zero_e50_running", 32'(running), 32'd1);
        run_to(51);
        chk("zero_e51_done", 32'(done), 32'd1);
        chk("zero_cycle_cnt", 32'(cycle_cnt), 32'd1);
        chk("zero_pass", 32'(pass), 32'd1);

        // 3. Asynchronous reset in the middle of RUN
        do_start(16'd4, 16'd100);
        run_to(60);
        chk("ar_pre_running", 32'(running), 32'd1);
        chk("ar_pre_cycle_cnt", 32'(cycle_cnt), 32'd7);
        #2;
        ext_reset = 1'b1;
        #1;
        chk("ar_rst_out", 32'(rst_out), 32'hF);
        chk("ar_running", 32'(running), 32'd0);
        chk("ar_cycle_cnt", 32'(cycle_cnt), 32'd0);
        // start coinciding with reset must lose
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ar_start_vs_reset", 32'(rst_out), 32'hF);
        #2;
        ext_reset = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("ar_idle_rst", 32'(rst_out), 32'hF);
        chk("ar_idle_running", 32'(running), 32'd0);
        chk("ar_idle_done", 32'(done), 32'd0);
        // From IDLE a fresh short sequence runs normally
        do_start(16'd2, 16'd2);
        run_to(2);
        chk("ar_new_e2_rst", 32'(rst_out), 32'hF);
        run_to(3);
        chk("ar_new_e3_rst", 32'(rst_out), 32'hE);
        run_to(52);
        chk("ar_new_e52_done", 32'(done), 32'd0);
        run_to(53);
        chk("ar_new_e53_done", 32'(done), 32'd1);
        chk("ar_new_cycle_cnt", 32'(cycle_cnt), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
